// File: rtl/rob_controller_pkg.sv
// Shared ROB definitions: sizing constants, tag/count types and the pointer
// helpers (wrap-around advance and age compare relative to the head).
// Tags run 1..ROB_SIZE; tag 0 means "no tag".
package rob_controller_pkg;

    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = $clog2(ROB_SIZE + 1);
    localparam int CNT_W    = $clog2(ROB_SIZE + 1);
    localparam int IDX_W    = $clog2(ROB_SIZE);

    typedef logic [TAG_W-1:0] rob_tag_t;
    typedef logic [CNT_W-1:0] rob_cnt_t;
    typedef logic [IDX_W-1:0] rob_idx_t;

    // Pointer advance: ROB_SIZE wraps back to 1.
    function automatic rob_tag_t rob_next(input rob_tag_t t);
        return (t == rob_tag_t'(ROB_SIZE)) ? rob_tag_t'(1) : rob_tag_t'(t + 1'b1);
    endfunction

    // Bit position of a (non-zero) tag in the flat valid/ready vectors.
    function automatic rob_idx_t rob_idx(input rob_tag_t t);
        return rob_idx_t'(t - 1'b1);
    endfunction

    // Distance of a tag from the head, 0..ROB_SIZE-1; smaller means older.
    function automatic rob_tag_t rob_age(input rob_tag_t t, input rob_tag_t head);
        logic [TAG_W:0] d;
        d = {1'b0, t} + (TAG_W+1)'(ROB_SIZE) - {1'b0, head};
        if (d >= (TAG_W+1)'(ROB_SIZE))
            d = d - (TAG_W+1)'(ROB_SIZE);
        return d[TAG_W-1:0];
    endfunction

    // True when tag a is strictly older than tag b.
    function automatic logic rob_older(input rob_tag_t a, input rob_tag_t b,
                                       input rob_tag_t head);
        return rob_age(a, head) < rob_age(b, head);
    endfunction

endpackage

// File: rtl/rob_controller_if.sv
// ROB bookkeeping bus: dispatch allocation, two CDB writebacks, in-order
// retire, mispredict flush and occupancy status.
//   master : core side (drives requests, writebacks, retire ack, flush)
//   slave  : the ROB controller
interface rob_controller_if;
    import rob_controller_pkg::*;

    logic     alloc_req;
    logic     alloc_ack;
    rob_tag_t alloc_tag;
    logic     wb1_valid;
    rob_tag_t wb1_tag;
    logic     wb2_valid;
    rob_tag_t wb2_tag;
    logic     retire_valid;
    rob_tag_t retire_tag;
    logic     retire_ack;
    logic     flush;
    rob_tag_t flush_tag;
    logic     rob_full;
    logic     rob_empty;
    rob_cnt_t rob_count;

    modport master (
        output alloc_req, wb1_valid, wb1_tag, wb2_valid, wb2_tag,
               retire_ack, flush, flush_tag,
        input  alloc_ack, alloc_tag, retire_valid, retire_tag,
               rob_full, rob_empty, rob_count
    );

    modport slave (
        input  alloc_req, wb1_valid, wb1_tag, wb2_valid, wb2_tag,
               retire_ack, flush, flush_tag,
        output alloc_ack, alloc_tag, retire_valid, retire_tag,
               rob_full, rob_empty, rob_count
    );
endinterface

// File: rtl/rob_controller.sv
// ROB controller: head/tail/count pointers and per-entry valid/ready bits.
// Grants allocation tags, marks completions from two CDBs, hands the head
// to retire in order and squashes younger entries on a mispredict.
// Ports:
//   clk   - core clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - rob_controller_if.slave (alloc, wb1/wb2, retire, flush, status)
module rob_controller
    import rob_controller_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    rob_controller_if.slave bus
);

    rob_tag_t            head_q, head_d;
    rob_tag_t            tail_q, tail_d;
    rob_cnt_t            count_q, count_d;
    logic [ROB_SIZE-1:0] valid_q, valid_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    logic [ROB_SIZE-1:0] squash;

    logic full, retire_valid, alloc_ack, retire_fire, flush_ok;

    // Out-of-range tags (0 or above ROB_SIZE) never address a live entry.
    function automatic logic tag_live(input rob_tag_t t, input logic [ROB_SIZE-1:0] v);
        if (t == '0 || t > rob_tag_t'(ROB_SIZE))
            return 1'b0;
        return v[rob_idx(t)];
    endfunction

    assign full         = (count_q == rob_cnt_t'(ROB_SIZE));
    assign retire_valid = valid_q[rob_idx(head_q)] & ready_q[rob_idx(head_q)];
    // No full-bypass: a same-cycle retire does not make room for this alloc.
    assign alloc_ack    = bus.alloc_req & ~full & ~bus.flush;
    assign retire_fire  = retire_valid & bus.retire_ack;
    assign flush_ok     = bus.flush & tag_live(bus.flush_tag, valid_q);

    assign bus.alloc_ack    = alloc_ack;
    assign bus.alloc_tag    = tail_q;
    assign bus.retire_valid = retire_valid;
    assign bus.retire_tag   = head_q;
    assign bus.rob_full     = full;
    assign bus.rob_empty    = (count_q == '0);
    assign bus.rob_count    = count_q;

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        squash  = '0;

        // Live entries strictly younger than the surviving branch tag.
        for (int i = 0; i < ROB_SIZE; i++)
            squash[i] = valid_q[i] & rob_older(bus.flush_tag, rob_tag_t'(i + 1), head_q);

        if (bus.wb1_valid && tag_live(bus.wb1_tag, valid_q))
            ready_d[rob_idx(bus.wb1_tag)] = 1'b1;
        if (bus.wb2_valid && tag_live(bus.wb2_tag, valid_q))
            ready_d[rob_idx(bus.wb2_tag)] = 1'b1;

        if (retire_fire) begin
            valid_d[rob_idx(head_q)] = 1'b0;
            ready_d[rob_idx(head_q)] = 1'b0;
            head_d = rob_next(head_q);
        end

        if (flush_ok) begin
            // Applied after writeback so completions to squashed tags are dropped.
            valid_d = valid_d & ~squash;
            ready_d = ready_d & ~squash;
            tail_d  = rob_next(bus.flush_tag);
            count_d = rob_cnt_t'(rob_age(bus.flush_tag, head_q)) + rob_cnt_t'(1)
                      - rob_cnt_t'(retire_fire);
        end else begin
            if (alloc_ack) begin
                valid_d[rob_idx(tail_q)] = 1'b1;
                ready_d[rob_idx(tail_q)] = 1'b0;
                tail_d = rob_next(tail_q);
            end
            case ({alloc_ack, retire_fire})
                2'b10:   count_d = count_q + rob_cnt_t'(1);
                2'b01:   count_d = count_q - rob_cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= rob_tag_t'(1);
            tail_q  <= rob_tag_t'(1);
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

endmodule
